latch_elastic: RTL and testbench

LATCH_ELASTIC -- requirements
Module: latch_elastic

---
 rtl/latch_elastic_pkg.sv | 16 +
 rtl/latch_elastic.sv | 93 +++++++++
 tb/tb_latch_elastic.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_elastic_pkg.sv
// Shared CPU defines: pipeline-latch state encoding and global enables.
//   RESET_ENABLE / STALL_ENABLE : CPU-wide feature enables.
//   latch_state_e               : elastic latch occupancy states.
package latch_elastic_pkg;

  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } latch_state_e;

endpackage

// File: rtl/latch_elastic.sv
// Two-entry elastic pipeline latch (output register + skid register).
// Drop-in replacement for a stall-vector latch between CPU stages.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   flush            : squash all held entries
//   up_valid/up_data : upstream offer; up_ready is registered (no path from down_ready)
//   down_valid/data  : presented entry; down_ready consumes it
//   occupancy        : held entries, 0..2
module latch_elastic
  import latch_elastic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter bit          CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [DATA_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [1:0]            occupancy
);

  latch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  up_ready_q, up_ready_d;
  logic                  accept, consume;

  assign accept  = up_valid & up_ready_q;
  assign consume = down_valid & down_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = up_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && consume) begin
          out_d = up_data;
        end else if (accept) begin
          skid_d  = up_data;
          state_d = StTwo;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (consume) begin
          out_d   = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush beats any simultaneous accept or consume.
    if (flush) begin
      state_d = StEmpty;
      out_d   = '0;
      skid_d  = '0;
    end
    // Ready is precomputed from the next state so the output is a plain flop.
    up_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StEmpty;
      out_q      <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign down_valid = (state_q != StEmpty);
  assign occupancy  = state_q;
  assign down_data  = (CLEAR_ON_BUBBLE && !down_valid) ? '0 : out_q;

endmodule

// File: tb/tb_latch_elastic.sv
module tb_latch_elastic;

  localparam int unsigned W = 64;

  logic         clock = 1'b0;
  logic         reset, flush, up_valid, down_ready;
  logic [W-1:0] up_data;
  logic         up_ready, down_valid;
  logic [W-1:0] down_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] sb[$];

  latch_elastic #(.DATA_WIDTH(W), .CLEAR_ON_BUBBLE(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  // Scoreboard cycle: compare presented outputs against the model queue, then update it
  // with this cycle's accept/consume and advance one clock (sampling #1 after the edge).
  task automatic tick();
    logic exp_rdy, acc, con;
    exp_rdy = (sb.size() < 2);
    if (chk_en) begin
      checks++;
      if (up_ready !== exp_rdy) begin
        errors++;
        $display("FAIL sb_up_ready got %b exp %b t=%0t", up_ready, exp_rdy, $time);
      end
      checks++;
      if (occupancy !== 2'(sb.size())) begin
        errors++;
        $display("FAIL sb_occupancy got %0d exp %0d t=%0t", occupancy, sb.size(), $time);
      end
      checks++;
      if (sb.size() > 0) begin
        if (down_valid !== 1'b1 || down_data !== sb[0]) begin
          errors++;
          $display("FAIL sb_data got v=%b d=%h exp v=1 d=%h t=%0t",
                   down_valid, down_data, sb[0], $time);
        end
      end else if (down_valid !== 1'b0 || down_data !== '0) begin
        errors++;
        $display("FAIL sb_bubble got v=%b d=%h exp v=0 d=0 t=%0t", down_valid, down_data, $time);
      end
    end
    acc = up_valid && exp_rdy;
    con = (sb.size() > 0) && down_ready;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) sb.push_back(up_data);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; up_valid = 0; up_data = '0; down_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    chk_en = 0;
    tick();
    tick();
    reset = 0;
    chk_en = 1;
    checks++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_data !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h occ=%0d exp rdy=1 v=0 d=0 occ=0",
               up_ready, down_valid, down_data, occupancy);
    end
  endtask

  task automatic test_stream();
    down_ready = 1;
    for (int i = 0; i < 4; i++) begin
      up_valid = (i < 3);
      up_data  = (i < 3) ? W'(i + 1) : '0;
      if (i < 3) begin
        checks++;
        if (up_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready got %b exp 1 i=%0d", up_ready, i);
        end
      end
      tick();
      if (i < 3) begin
        checks++;
        if (down_valid !== 1'b1 || down_data !== W'(i + 1)) begin
          errors++;
          $display("FAIL stream_data got v=%b d=%h exp v=1 d=%h", down_valid, down_data, W'(i + 1));
        end
      end
    end
    up_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    up_valid = 1; up_data = 64'hA; tick();
    up_data = 64'hB; tick();
    checks++;
    if (occupancy !== 2'd2 || up_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, up_ready);
    end
    up_data = 64'hC; tick();
    checks++;
    if (occupancy !== 2'd2 || down_data !== 64'hA) begin
      errors++;
      $display("FAIL bp_hold got occ=%0d d=%h exp occ=2 d=a", occupancy, down_data);
    end
    down_ready = 1;
    tick();
    checks++;
    if (down_data !== 64'hB) begin
      errors++;
      $display("FAIL bp_order_b got %h exp b", down_data);
    end
    tick();
    up_valid = 0;
    checks++;
    if (down_data !== 64'hC) begin
      errors++;
      $display("FAIL bp_order_c got %h exp c", down_data);
    end
    tick();
    checks++;
    if (down_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%b exp 0", down_valid);
    end
  endtask

  task automatic test_flush_two();
    idle_inputs();
    up_valid = 1; up_data = 64'h11; tick();
    up_data = 64'h22; tick();
    up_valid = 0;
    flush = 1; down_ready = 1;
    tick();
    flush = 0;
    checks++;
    if (occupancy !== 2'd0 || down_valid !== 1'b0 || down_data !== '0) begin
      errors++;
      $display("FAIL flush_two got occ=%0d v=%b d=%h exp occ=0 v=0 d=0",
               occupancy, down_valid, down_data);
    end
    tick();
    tick();
  endtask

  task automatic test_flush_accept();
    idle_inputs();
    up_valid = 1; up_data = 64'h33; tick();
    up_data = 64'h55; flush = 1; tick();
    flush = 0; up_valid = 0; down_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (down_valid !== 1'b0 || occupancy !== 2'd0 || down_data === 64'h55) begin
        errors++;
        $display("FAIL flush_accept got v=%b occ=%0d d=%h exp v=0 occ=0",
                 down_valid, occupancy, down_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    up_valid = 1; up_data = 64'h77; tick();
    up_data = 64'h88; tick();
    reset = 1; flush = 1; up_data = 64'h99; tick();
    reset = 0; flush = 0; up_valid = 0; down_ready = 1;
    checks++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || down_data !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b v=%b d=%h occ=%0d exp rdy=1 v=0 d=0 occ=0",
               up_ready, down_valid, down_data, occupancy);
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic r0;
    idle_inputs();
    for (int i = 0; i < 10000; i++) begin
      up_valid   = $urandom_range(0, 1) == 1;
      up_data    = {32'hC0DE_0000, 32'(i)};
      down_ready = $urandom_range(0, 1) == 1;
      // up_ready must not move when down_ready flips within the cycle.
      r0 = up_ready;
      down_ready = ~down_ready;
      #1;
      checks++;
      if (up_ready !== r0) begin
        errors++;
        $display("FAIL rand_ready_path got %b exp %b i=%0d", up_ready, r0, i);
      end
      down_ready = ~down_ready;
      #1;
      tick();
    end
    up_valid = 0; down_ready = 1;
    tick(); tick(); tick();
    checks++;
    if (sb.size() != 0 || down_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got left=%0d v=%b exp left=0 v=0", sb.size(), down_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_flush_accept();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
